// File: rtl/filter_read_ctrl_pkg.sv
// Shared types and constants for the filter scratchpad read sequencer.
package filter_ctrl_pkg;

  localparam int FILTER_SIZE_REG_SIZE = 8;
  localparam int NUM_FILTER_REG_SIZE  = 8;
  localparam int ROUND_REG_SIZE       = 8;
  localparam int READ_LAT             = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/filter_read_ctrl_if.sv
// Job descriptor, flow-control and strobe bundle between the conv controller and the read sequencer.
interface filter_read_ctrl_if
  import filter_ctrl_pkg::*;
();

  logic                            start;
  logic                            clear;
  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size;
  logic [NUM_FILTER_REG_SIZE-1:0]  num_filters;
  logic [ROUND_REG_SIZE-1:0]       num_rounds;
  logic                            sp_valid;
  logic                            mac_ready;
  logic                            put_filter;
  logic                            next_filter;
  logic                            end_of_filter;
  logic                            rd_en;
  logic                            rd_valid;
  logic                            rd_last;
  logic                            busy;
  logic                            done;

  modport master (
    output start, clear, filter_size, num_filters, num_rounds, sp_valid, mac_ready,
    input  put_filter, next_filter, end_of_filter, rd_en, rd_valid, rd_last, busy, done
  );

  modport slave (
    input  start, clear, filter_size, num_filters, num_rounds, sp_valid, mac_ready,
    output put_filter, next_filter, end_of_filter, rd_en, rd_valid, rd_last, busy, done
  );

endinterface

// File: rtl/filter_read_ctrl_wrap.sv
// Enabled counter that wraps to zero at a programmable terminal value and flags the wrap.
module wrap_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;

  // Wrap fires on the enabled cycle that sits at the terminal value, so cnt never exceeds term.
  assign wrap = en & (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/filter_read_ctrl.sv
// Filter scratchpad read sequencer: walks element/filter/round counters under sp_valid & mac_ready
// and emits address-generator strobes, read enables and a latency-aligned valid/last sideband.
//
// state | meaning
// IDLE  | waiting for start; descriptor latched on accept
// RUN   | issuing one element per fire cycle
// DRAIN | final read in flight, last rd_valid emerges
// DONE  | one-cycle done pulse
module filter_read_ctrl
  import filter_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  filter_read_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]                      state;
  logic [1:0]                      state_nxt;
  logic [FILTER_SIZE_REG_SIZE-1:0] fs_q;
  logic [NUM_FILTER_REG_SIZE-1:0]  nf_q;
  logic [ROUND_REG_SIZE-1:0]       nr_q;
  logic [READ_LAT-1:0]             vld_pipe;
  logic [READ_LAT-1:0]             last_pipe;

  logic accept;
  logic zero_job;
  logic abort;
  logic fire;
  logic cnt_clr;
  logic elem_wrap;
  logic filt_wrap;
  logic rnd_wrap;

  assign accept   = (state == ST_IDLE) & bus.start;
  assign zero_job = (bus.filter_size == '0) | (bus.num_filters == '0) | (bus.num_rounds == '0);
  assign abort    = bus.clear & (state != ST_IDLE);
  // clear wins over fire so an aborted cycle never leaks a strobe or a read
  assign fire     = (state == ST_RUN) & bus.sp_valid & bus.mac_ready & ~bus.clear;
  assign cnt_clr  = accept | abort;

  wrap_counter #(.WIDTH(FILTER_SIZE_REG_SIZE)) u_elem_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (fire),
    .term (fs_q - FILTER_SIZE_REG_SIZE'(1)),
    .wrap (elem_wrap)
  );

  wrap_counter #(.WIDTH(NUM_FILTER_REG_SIZE)) u_filt_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (elem_wrap),
    .term (nf_q - NUM_FILTER_REG_SIZE'(1)),
    .wrap (filt_wrap)
  );

  wrap_counter #(.WIDTH(ROUND_REG_SIZE)) u_rnd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (filt_wrap),
    .term (nr_q - ROUND_REG_SIZE'(1)),
    .wrap (rnd_wrap)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = zero_job ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.clear) begin
          state_nxt = ST_IDLE;
        end else if (rnd_wrap) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = bus.clear ? ST_IDLE : ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_q <= '0;
      nf_q <= '0;
      nr_q <= '0;
    end else if (accept) begin
      fs_q <= bus.filter_size;
      nf_q <= bus.num_filters;
      nr_q <= bus.num_rounds;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (abort) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= fire;
      last_pipe[0] <= elem_wrap;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign bus.put_filter    = fire;
  assign bus.rd_en         = fire;
  assign bus.next_filter   = elem_wrap;
  assign bus.end_of_filter = filt_wrap;
  assign bus.rd_valid      = vld_pipe[READ_LAT-1];
  assign bus.rd_last       = last_pipe[READ_LAT-1];
  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = (state == ST_DONE) & ~bus.clear;

endmodule

// File: tb/tb_filter_read_ctrl.sv
// Self-checking bench for filter_read_ctrl: a flat element-index model predicts every cycle's outputs.
module tb_filter_read_ctrl;
  import filter_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  filter_read_ctrl_if bus();

  filter_read_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observation order: put_filter, rd_en, next_filter, end_of_filter, rd_valid, rd_last, busy, done
  function automatic logic [7:0] obs_vec();
    return {bus.put_filter, bus.rd_en, bus.next_filter, bus.end_of_filter,
            bus.rd_valid, bus.rd_last, bus.busy, bus.done};
  endfunction

  // Runs one job starting at cycle 0 (called just after a posedge) and checks every cycle
  // against the flat model: element k of N is last-of-filter when k%fs==fs-1 and
  // last-of-bank when k%(fs*nf)==fs*nf-1.
  task automatic drive_and_check_job(input int fs, input int nf, input int nr,
                                     input int stall_pct, input logic [63:0] mr_low,
                                     input bit busy_start, input string tag,
                                     output int done_cyc, output int n_put,
                                     output int n_nxt, output int n_eof);
    int ntot, k, ph, limit;
    bit pf, pl, sv, mr, e_fire, e_nxt, e_eof, finished;
    logic [7:0] exp_v, got_v;
    ntot = fs * nf * nr;
    k = 0; pf = 0; pl = 0; finished = 0;
    done_cyc = -1; n_put = 0; n_nxt = 0; n_eof = 0;
    limit = 10 * ntot + 20;
    bus.filter_size = 8'(fs);
    bus.num_filters = 8'(nf);
    bus.num_rounds  = 8'(nr);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ph = (ntot == 0) ? 2 : 0;
    for (int c = 1; c <= limit && !finished; c++) begin
      sv = (int'($urandom_range(99)) >= stall_pct);
      mr = (int'($urandom_range(99)) >= stall_pct) && !(c < 64 && mr_low[c]);
      bus.sp_valid  = sv;
      bus.mac_ready = mr;
      bus.start     = busy_start && (c == 2);
      if (bus.start) begin
        bus.filter_size = 8'd1;
        bus.num_filters = 8'd1;
        bus.num_rounds  = 8'd1;
      end
      @(negedge clk);
      e_fire = (ph == 0) && sv && mr;
      e_nxt = 1'b0;
      e_eof = 1'b0;
      if (e_fire) begin
        e_nxt = ((k % fs) == fs - 1);
        e_eof = ((k % (fs * nf)) == fs * nf - 1);
      end
      exp_v = {e_fire, e_fire, e_nxt, e_eof, pf, pl, (ph != 3), (ph == 2)};
      got_v = obs_vec();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d pf/re/nf/eof/rv/rl/busy/done got %b exp %b",
                 tag, c, got_v, exp_v);
      end
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (bus.put_filter === 1'b1) n_put++;
      if (bus.next_filter === 1'b1) n_nxt++;
      if (bus.end_of_filter === 1'b1) n_eof++;
      pf = e_fire;
      pl = e_nxt;
      if (ph == 3) finished = 1;
      else if (ph == 2) ph = 3;
      else if (ph == 1) ph = 2;
      else if (e_fire) begin
        k++;
        if (k == ntot) ph = 1;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout got idle=0 exp idle=1 within %0d cycles", tag, limit);
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.clear = 0; bus.sp_valid = 0; bus.mac_ready = 0;
    bus.filter_size = 0; bus.num_filters = 0; bus.num_rounds = 0;
    rst = 1'b1;
    #3;
    checks++;
    if (obs_vec() !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", obs_vec(), 8'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== 8'b0) begin
      errors++;
      $display("FAIL post_reset_idle got %b exp %b", obs_vec(), 8'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, np, nn, ne;
    drive_and_check_job(3, 2, 1, 0, 64'h0, 1'b0, "basic", dc, np, nn, ne);
    checks++; if (dc !== 8) begin errors++; $display("FAIL basic_done_cycle got %0d exp 8", dc); end
    checks++; if (np !== 6) begin errors++; $display("FAIL basic_put_count got %0d exp 6", np); end
    checks++; if (nn !== 2) begin errors++; $display("FAIL basic_next_count got %0d exp 2", nn); end
    checks++; if (ne !== 1) begin errors++; $display("FAIL basic_eof_count got %0d exp 1", ne); end
  endtask

  task automatic test_stall();
    int dc, np, nn, ne;
    drive_and_check_job(3, 2, 1, 0, 64'h1C, 1'b0, "stall", dc, np, nn, ne);
    checks++; if (dc !== 11) begin errors++; $display("FAIL stall_done_cycle got %0d exp 11", dc); end
    checks++; if (np !== 6) begin errors++; $display("FAIL stall_put_count got %0d exp 6", np); end
  endtask

  task automatic test_fs1();
    int dc, np, nn, ne;
    drive_and_check_job(1, 4, 2, 0, 64'h0, 1'b0, "fs1", dc, np, nn, ne);
    checks++; if (dc !== 10) begin errors++; $display("FAIL fs1_done_cycle got %0d exp 10", dc); end
    checks++; if (nn !== 8) begin errors++; $display("FAIL fs1_next_count got %0d exp 8", nn); end
    checks++; if (ne !== 2) begin errors++; $display("FAIL fs1_eof_count got %0d exp 2", ne); end
  endtask

  task automatic test_zero_field();
    int dc, np, nn, ne;
    drive_and_check_job(3, 0, 2, 0, 64'h0, 1'b0, "zero_nf", dc, np, nn, ne);
    checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", dc); end
    checks++; if (np !== 0) begin errors++; $display("FAIL zero_put_count got %0d exp 0", np); end
    drive_and_check_job(0, 2, 1, 0, 64'h0, 1'b0, "zero_fs", dc, np, nn, ne);
    checks++; if (dc !== 1) begin errors++; $display("FAIL zero_fs_done_cycle got %0d exp 1", dc); end
  endtask

  task automatic test_busy_start();
    int dc, np, nn, ne;
    drive_and_check_job(3, 2, 1, 0, 64'h0, 1'b1, "busy_start", dc, np, nn, ne);
    checks++; if (dc !== 8) begin errors++; $display("FAIL busy_start_done_cycle got %0d exp 8", dc); end
  endtask

  task automatic test_clear();
    logic [7:0] exp_tab [1:4];
    int dc, np, nn, ne;
    exp_tab[1] = 8'b1100_0010;
    exp_tab[2] = 8'b1100_1010;
    exp_tab[3] = 8'b0000_1010;
    exp_tab[4] = 8'b0000_0000;
    bus.filter_size = 8'd3; bus.num_filters = 8'd2; bus.num_rounds = 8'd1;
    bus.sp_valid = 1'b1; bus.mac_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.clear = (c == 3);
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_tab[c]) begin
        errors++;
        $display("FAIL clear cycle %0d got %b exp %b", c, obs_vec(), exp_tab[c]);
      end
      @(posedge clk); #1;
    end
    bus.clear = 1'b0;
    drive_and_check_job(3, 2, 1, 0, 64'h0, 1'b0, "after_clear", dc, np, nn, ne);
    checks++; if (dc !== 8) begin errors++; $display("FAIL after_clear_done_cycle got %0d exp 8", dc); end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    bus.filter_size = 8'd3; bus.num_filters = 8'd2; bus.num_rounds = 8'd1;
    bus.sp_valid = 1'b1; bus.mac_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b exp %b", obs_vec(), 8'b0);
    end
    #1 rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d busy/done cycles exp 0", done_seen);
    end
  endtask

  task automatic test_max_fields();
    int dc, np, nn, ne;
    drive_and_check_job(255, 1, 1, 0, 64'h0, 1'b0, "max_fs", dc, np, nn, ne);
    checks++; if (dc !== 257) begin errors++; $display("FAIL max_fs_done_cycle got %0d exp 257", dc); end
    drive_and_check_job(1, 1, 255, 0, 64'h0, 1'b0, "max_nr", dc, np, nn, ne);
    checks++; if (ne !== 255) begin errors++; $display("FAIL max_nr_eof_count got %0d exp 255", ne); end
    drive_and_check_job(1, 255, 1, 0, 64'h0, 1'b0, "max_nf", dc, np, nn, ne);
    checks++; if (ne !== 1) begin errors++; $display("FAIL max_nf_eof_count got %0d exp 1", ne); end
    drive_and_check_job(255, 2, 2, 20, 64'h0, 1'b0, "max_mix", dc, np, nn, ne);
    checks++; if (np !== 1020) begin errors++; $display("FAIL max_mix_put_count got %0d exp 1020", np); end
  endtask

  task automatic test_random();
    int dc, np, nn, ne, fs, nf, nr;
    for (int j = 0; j < 10; j++) begin
      fs = int'($urandom_range(5, 1));
      nf = int'($urandom_range(4, 1));
      nr = int'($urandom_range(3, 1));
      if ($urandom_range(4) == 0) nf = 0;
      drive_and_check_job(fs, nf, nr, 30, 64'h0, 1'b0, "random", dc, np, nn, ne);
      checks++;
      if (np !== fs * nf * nr) begin
        errors++;
        $display("FAIL random_put_count job %0d got %0d exp %0d", j, np, fs * nf * nr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_fs1();
    test_zero_field();
    test_busy_start();
    test_clear();
    test_reset_mid();
    test_max_fields();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_read_ctrl.md
# filter_read_ctrl

Sequencing controller for the filter scratchpad read path of the convolution engine. It takes a job descriptor (filter size, filter count, round count), then drives the advance and wrap strobes of the filter read-address generator. It also issues scratchpad read enables paced by downstream MAC back-pressure and scratchpad readiness, and returns a data-valid/last sideband aligned to the one-cycle scratchpad read latency. It sits between the top-level convolution controller and the filter address generator and scratchpad.

## Interface
- FILTER_SIZE_REG_SIZE, 8, width of filter_size and the element counter
- NUM_FILTER_REG_SIZE, 8, width of num_filters and the filter counter
- ROUND_REG_SIZE, 8, width of num_rounds and the round counter
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle job launch; sampled only in IDLE
- clear  input  1  synchronous abort; returns to IDLE with no done pulse
- filter_size  input  FILTER_SIZE_REG_SIZE  elements per filter; latched on accepted start
- num_filters  input  NUM_FILTER_REG_SIZE  filters per round; latched on accepted start
- num_rounds  input  ROUND_REG_SIZE  passes over the full filter bank; latched on accepted start
- sp_valid  input  1  scratchpad holds valid filter data
- mac_ready  input  1  downstream accepts one element this cycle
- put_filter  output  1  advance element pointer (to the address generator)
- next_filter  output  1  advance to the next filter base
- end_of_filter  output  1  qualifies next_filter as wrap to filter 0
- rd_en  output  1  scratchpad read enable
- rd_valid  output  1  read data valid; rd_en delayed one cycle
- rd_last  output  1  with rd_valid, marks the last element of a filter
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at job completion

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - start=1 latches the descriptor and clears elem_cnt, filt_cnt and rnd_cnt.
  - If any descriptor field is 0, go to DONE. No strobes are issued.
  - Otherwise go to RUN.
- **RUN**
  - Issue condition: fire = sp_valid & mac_ready.
  - On fire, assert rd_en and put_filter and increment elem_cnt.
  - When elem_cnt == filter_size-1 on fire:
    - the element is last; elem_cnt returns to 0.
    - next_filter=1 in the same cycle.
  - On the last element of filter num_filters-1:
    - end_of_filter=1 alongside next_filter.
    - filt_cnt returns to 0 and rnd_cnt increments.
  - On the last element of the last filter of round num_rounds-1, go to DRAIN.
  - No fire means no strobes and all counters hold.
- **DRAIN**: one cycle, so the final rd_valid/rd_last emerges. Then go to DONE.
- **DONE**: done=1 for one cycle, then go to IDLE.
- **clear**: takes effect in any non-IDLE state. Next state is IDLE, counters are zeroed, and the rd_valid pipeline is flushed. clear has priority over fire.
- **start while busy**: ignored. The latched descriptor is not altered mid-job.
- **Counter arithmetic**: counters are unsigned at their field widths. Comparisons are against the latched field minus 1, computed at the same width; this is safe because 0 is rejected in IDLE. A maximum field value (all ones) must complete without overflow.

## Timing
- **Reset values**: all outputs are 0, state is IDLE, and counters and latched fields are 0.
- **Strobe timing**: put_filter, next_filter, end_of_filter and rd_en are Moore/Mealy combinational outputs of RUN & fire, valid in the fire cycle.
- **rd_valid / rd_last**: registered, exactly one cycle after the corresponding rd_en.
- **Zero-stall job** (start accepted in cycle 0, N = filter_size·num_filters·num_rounds):
  - rd_en is high in cycles 1..N;
  - DRAIN is in cycle N+1 and the last rd_valid is in cycle N+1;
  - done is in cycle N+2;
  - busy is high in cycles 1..N+2.
- **Zero-field job**: done in cycle 1, no strobes.
- **filter_size=1**: every fire carries put_filter, next_filter and rd_last.
- **Reset mid-job**: outputs drop to 0 asynchronously and no done is produced.

## Structure
- Package filter_ctrl_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - the localparam read latency, READ_LAT = 1.
- One natural sub-module is wrap_counter (parameterised width, enable, terminal value, wrap pulse output). It is instantiated three times, for element, filter and round, chained through the wrap pulses.
- The FSM and the output decode live in filter_read_ctrl.

## Test plan
- filter_size=3, num_filters=2, num_rounds=1, sp_valid=mac_ready=1 → 6 put_filter pulses in cycles 1–6; next_filter in cycles 3 and 6; end_of_filter only in cycle 6; rd_last with rd_valid in cycles 4 and 7; done in cycle 8.
- Same job with mac_ready low in cycles 2–4 → counters hold, no strobes during the stall; all strobes shift by 3 cycles; done in cycle 11.
- filter_size=1, num_filters=4, num_rounds=2 → 8 fires; next_filter on every fire; end_of_filter in cycles 4 and 8; done in cycle 10.
- num_filters=0 → done in cycle 1; put_filter, rd_en and next_filter stay 0; busy high for cycle 1 only.
- clear asserted in cycle 3 of the first job → IDLE in cycle 4 with no done and no rd_valid after cycle 4; a new start in cycle 5 runs normally with fresh counters.
- Asynchronous rst pulse mid-RUN → all outputs 0 immediately; start pulses during busy are ignored (a second start in cycle 2 changes nothing).
